// File: rtl/ram_dma.sv
// ram_dma: single-clock block-transfer initiator for the 256x32 data RAM.
// Copies len words from src_addr to dst_addr (ascending, pointers wrap
// modulo 2^AW), one read cycle plus one write cycle per word. Holds the RAM
// port for the whole transfer; all outputs are registered.
//
// Optional feature macro: RAM_DMA_FILL_EN
//   defined   -> mode/fill_data ports exist; mode=1 writes fill_data to len
//                consecutive words at one cycle per word (no reads).
//   undefined -> copy-only block.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             transfer request, sampled only in IDLE
//   src_addr/dst_addr first source / destination word address
//   len               word count 0..2^AW (AW+1 bits)
//   busy, done        transfer in progress / one-cycle completion pulse
//   nce               RAM chip enable, active-low
//   MemRead/MemWrite  RAM strobes, never high together
//   address, wdata    RAM word address / write data
//   rdata             RAM read data (valid while nce=0 and MemRead=1)
//   mode, fill_data   fill select and pattern (RAM_DMA_FILL_EN only)
module ram_dma #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          nce,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] address,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata
`ifdef RAM_DMA_FILL_EN
  ,
  input  logic          mode,
  input  logic [DW-1:0] fill_data
`endif
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state, next_state;
  logic [AW-1:0] src_p, src_p_nxt;
  logic [AW-1:0] dst_p, dst_p_nxt;
  logic [AW:0]   rem, rem_nxt;

  // Transfer mode as latched at start, and the mode the next cycle will use.
  logic          fill_cur;
  logic          fill_nxt;
  logic          start_fill;
  logic [DW-1:0] pattern_nxt;

`ifdef RAM_DMA_FILL_EN
  logic          mode_r, mode_nxt;
  logic [DW-1:0] fill_r, fill_r_nxt;

  assign fill_cur    = mode_r;
  assign fill_nxt    = mode_nxt;
  assign start_fill  = mode;
  assign pattern_nxt = fill_r_nxt;
`else
  assign fill_cur    = 1'b0;
  assign fill_nxt    = 1'b0;
  assign start_fill  = 1'b0;
  assign pattern_nxt = '0;
`endif

  logic          nce_nxt, rd_nxt, wr_nxt, busy_nxt, done_nxt;
  logic [AW-1:0] address_nxt;
  logic [DW-1:0] wdata_nxt;

  // State, pointer and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      src_p    <= '0;
      dst_p    <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nce      <= 1'b1;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      address  <= '0;
      wdata    <= '0;
`ifdef RAM_DMA_FILL_EN
      mode_r   <= 1'b0;
      fill_r   <= '0;
`endif
    end else begin
      state    <= next_state;
      src_p    <= src_p_nxt;
      dst_p    <= dst_p_nxt;
      rem      <= rem_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      nce      <= nce_nxt;
      MemRead  <= rd_nxt;
      MemWrite <= wr_nxt;
      address  <= address_nxt;
      wdata    <= wdata_nxt;
`ifdef RAM_DMA_FILL_EN
      mode_r   <= mode_nxt;
      fill_r   <= fill_r_nxt;
`endif
    end
  end

  // Next state plus the pointer/counter values that go with it.
  always_comb begin
    next_state = state;
    src_p_nxt  = src_p;
    dst_p_nxt  = dst_p;
    rem_nxt    = rem;
`ifdef RAM_DMA_FILL_EN
    mode_nxt   = mode_r;
    fill_r_nxt = fill_r;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          src_p_nxt = src_addr;
          dst_p_nxt = dst_addr;
          rem_nxt   = len;
`ifdef RAM_DMA_FILL_EN
          mode_nxt   = mode;
          fill_r_nxt = fill_data;
`endif
          if (len == '0)      next_state = DONE;
          else if (start_fill) next_state = WR;
          else                 next_state = RD;
        end
      end
      RD: next_state = WR;
      WR: begin
        src_p_nxt = src_p + AW'(1);
        dst_p_nxt = dst_p + AW'(1);
        rem_nxt   = rem - (AW+1)'(1);
        if (rem == (AW+1)'(1)) next_state = DONE;
        else if (fill_cur)     next_state = WR;
        else                   next_state = RD;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from where the FSM is going.
  always_comb begin
    nce_nxt     = 1'b1;
    rd_nxt      = 1'b0;
    wr_nxt      = 1'b0;
    address_nxt = address;
    wdata_nxt   = wdata;
    busy_nxt    = (next_state != IDLE);
    done_nxt    = (next_state == DONE);
    unique case (next_state)
      RD: begin
        nce_nxt     = 1'b0;
        rd_nxt      = 1'b1;
        address_nxt = src_p_nxt;
      end
      WR: begin
        nce_nxt     = 1'b0;
        wr_nxt      = 1'b1;
        address_nxt = dst_p_nxt;
        // Copy mode only enters WR from RD, so rdata is the word just read.
        wdata_nxt   = fill_nxt ? pattern_nxt : rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: randomized self-checking bench for ram_dma with a RAM model
// (combinational read, negedge write) and a transfer-level reference model.
module tb_ram_dma;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
`ifdef RAM_DMA_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   len;
  logic          busy, done, nce, MemRead, MemWrite;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata, rdata;
`ifdef RAM_DMA_FILL_EN
  logic          mode;
  logic [DW-1:0] fill_data;
`endif

  always #5 clk = ~clk;

  ram_dma #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .nce(nce),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .wdata(wdata), .rdata(rdata)
`ifdef RAM_DMA_FILL_EN
    , .mode(mode), .fill_data(fill_data)
`endif
  );

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [7:0]    addr_log[$];
  int checks   = 0;
  int failures = 0;

  // RAM model: junk on rdata unless a read is actually being performed.
  assign rdata = (!nce && MemRead) ? mem[address] : 32'hBAD0_BAD0;
  always @(negedge clk) if (!nce && MemWrite) mem[address] = wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
  endtask

  task automatic mem_compare(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(name, 64'(bad), 64'(0));
  endtask

  task automatic drive_idle();
    start    = 1'b0;
    src_addr = 8'($urandom);
    dst_addr = 8'($urandom);
    len      = 9'($urandom);
`ifdef RAM_DMA_FILL_EN
    mode      = 1'($urandom_range(0, 1));
    fill_data = $urandom;
`endif
  endtask

  // Runs one transfer; called just after a rising edge with the DUT idle.
  // Checks every output on every cycle against the transfer-level model.
  task automatic do_xfer(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n,
                         input logic m, input logic [31:0] fv, output int done_cyc);
    int total;
    if (n == 0)  total = 1;
    else if (m)  total = int'(n) + 1;
    else         total = 2 * int'(n) + 1;
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    len      = n;
`ifdef RAM_DMA_FILL_EN
    mode      = m;
    fill_data = fv;
`endif
    addr_log.delete();
    done_cyc = -1;
    @(posedge clk); #1;
    for (int k = 1; k <= total + 1; k++) begin
      logic       e_rd, e_wr;
      logic [7:0] e_addr;
      logic [31:0] e_wd;
      int         i;
      e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
      if (k < total) begin
        if (m) begin
          i = k - 1; e_wr = 1'b1; e_addr = d + 8'(i); e_wd = fv;
        end else begin
          i = (k - 1) / 2;
          if (k % 2 == 1) begin
            e_rd = 1'b1; e_addr = s + 8'(i);
          end else begin
            e_wr = 1'b1; e_addr = d + 8'(i); e_wd = ref_mem[s + 8'(i)];
          end
        end
      end
      chk("busy", 64'(busy), 64'(k <= total));
      chk("done", 64'(done), 64'(k == total));
      chk("MemRead", 64'(MemRead), 64'(e_rd));
      chk("MemWrite", 64'(MemWrite), 64'(e_wr));
      chk("nce", 64'(nce), 64'(!(e_rd || e_wr)));
      if (e_rd || e_wr) begin
        chk("address", 64'(address), 64'(e_addr));
        addr_log.push_back(address);
      end
      if (e_wr) begin
        chk("wdata", 64'(wdata), 64'(e_wd));
        ref_mem[e_addr] = e_wd;
      end
      if (done && done_cyc < 0) done_cyc = k;
      // Requests and input changes mid-transfer must be ignored.
      drive_idle();
      if (k <= total) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int dc;
    logic [7:0] exp_wrap[6];
    exp_wrap = '{8'hFE, 8'h02, 8'hFF, 8'h03, 8'h00, 8'h04};
    reset = 1'b1;
    drive_idle();
    preload();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_nce", 64'(nce), 64'(1));
    chk("rst_rd", 64'(MemRead), 64'(0));
    chk("rst_wr", 64'(MemWrite), 64'(0));
    chk("rst_addr", 64'(address), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic copy with known data.
    for (int i = 0; i < 4; i++) begin
      mem[8'h10 + i] = 32'hA0 + i;
      ref_mem[8'h10 + i] = 32'hA0 + i;
    end
    do_xfer(8'h10, 8'h80, 9'd4, 1'b0, 32'h0, dc);
    chk("t1_done_cycle", 64'(dc), 64'(9));
    for (int i = 0; i < 4; i++) chk("t1_dst_word", 64'(mem[8'h80 + i]), 64'(32'hA0 + i));
    mem_compare("t1_mem");

    // Address wrap.
    do_xfer(8'hFE, 8'h02, 9'd3, 1'b0, 32'h0, dc);
    chk("wrap_len", 64'(addr_log.size()), 64'(6));
    for (int i = 0; i < 6 && i < addr_log.size(); i++) chk("wrap_addr", 64'(addr_log[i]), 64'(exp_wrap[i]));
    chk("wrap_done_cycle", 64'(dc), 64'(7));
    mem_compare("wrap_mem");

    // Zero-length.
    do_xfer(8'h33, 8'h44, 9'd0, 1'b0, 32'h0, dc);
    chk("len0_done_cycle", 64'(dc), 64'(1));
    mem_compare("len0_mem");

    // Full-memory self copy.
    do_xfer(8'h00, 8'h00, 9'd256, 1'b0, 32'h0, dc);
    chk("len256_done_cycle", 64'(dc), 64'(513));
    mem_compare("len256_mem");

    // Reset during the 2nd write of a len=4 copy.
    start = 1'b1; src_addr = 8'h20; dst_addr = 8'h60; len = 9'd4;
`ifdef RAM_DMA_FILL_EN
    mode = 1'b0;
`endif
    @(posedge clk); #1;           // cycle 1: RD word 0
    drive_idle();
    @(posedge clk); #1;           // cycle 2: WR word 0
    @(posedge clk); #1;           // cycle 3: RD word 1
    reset = 1'b1;
    @(posedge clk); #1;           // would have been WR word 1
    ref_mem[8'h60] = ref_mem[8'h20];
    chk("rstmid_nce", 64'(nce), 64'(1));
    chk("rstmid_rd", 64'(MemRead), 64'(0));
    chk("rstmid_wr", 64'(MemWrite), 64'(0));
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_done", 64'(done), 64'(0));
    chk("rstmid_addr", 64'(address), 64'(0));
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("rstmid_no_done", 64'({done, busy, nce}), 64'(3'b001));
    end
    mem_compare("rstmid_mem");

    if (FILL_EN) begin
      do_xfer(8'h00, 8'h40, 9'd5, 1'b1, 32'hDEADBEEF, dc);
      chk("fill_done_cycle", 64'(dc), 64'(6));
      for (int i = 0; i < 5; i++) chk("fill_word", 64'(mem[8'h40 + i]), 64'(32'hDEADBEEF));
      mem_compare("fill_mem");
    end

    // Randomized transfers, including overlapping ranges.
    for (int r = 0; r < 10; r++) begin
      logic [7:0] s, d;
      logic [8:0] n;
      logic m;
      s = 8'($urandom);
      d = (r % 3 == 0) ? s + 8'($urandom_range(1, 4)) : 8'($urandom);
      n = 9'($urandom_range(0, 24));
      m = FILL_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      do_xfer(s, d, n, m, $urandom, dc);
      mem_compare("rand_mem");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
